crc_frame_seq: RTL and testbench

CRC_FRAME_SEQ -- requirements
Module: crc_frame_seq

---
 rtl/crc_frame_seq.sv | 145 ++++++++++++++
 tb/tb_crc_frame_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_seq.sv
// Serial frame transmitter: shifts accepted bytes out LSB first, then appends
// the N-bit reflected CRC accumulated over the frame's data bits.
module crc_frame_seq #(
    parameter int unsigned    N    = 8,
    parameter logic [N-1:0]   FB   = 8'hcd,
    parameter logic [N-1:0]   INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_crc,
    output logic       out_eof,
    output logic       busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CRC_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, DATA, STALL, CRC} state_t;

    state_t        state, state_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [CW-1:0] crc_cnt, crc_cnt_nx;
    logic [N-1:0]  lfsr, lfsr_nx;
    logic          last, last_nx;
    logic          first, first_nx;

    // NOTE: every register, datapath included, is cleared by the async reset so
    // an abort mid-frame can never leak stale CRC or shift state into the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
            lfsr    <= '0;
            last    <= 1'b0;
            first   <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            crc_cnt <= crc_cnt_nx;
            lfsr    <= lfsr_nx;
            last    <= last_nx;
            first   <= first_nx;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path infers a latch.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        crc_cnt_nx = crc_cnt;
        lfsr_nx    = lfsr;
        last_nx    = last;
        first_nx   = first;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_sof    = 1'b0;
        out_crc    = 1'b0;
        out_eof    = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx   = DATA;
                    shreg_nx   = in_data;
                    last_nx    = in_last;
                    bit_cnt_nx = '0;
                    lfsr_nx    = INIT;
                    first_nx   = 1'b1;
                end
            end
            DATA: begin
                if (en) begin
                    out_valid  = 1'b1;
                    out_bit    = shreg[0];
                    out_sof    = first && (bit_cnt == 3'd0);
                    first_nx   = 1'b0;
                    shreg_nx   = shreg >> 1;
                    bit_cnt_nx = bit_cnt + 3'd1;
                    lfsr_nx    = (lfsr[0] ^ shreg[0]) ? ((lfsr >> 1) ^ FB) : (lfsr >> 1);
                    if (bit_cnt == 3'd7) begin
                        if (last) begin
                            state_nx   = CRC;
                            crc_cnt_nx = '0;
                        end else begin
                            // Byte boundary: take the next byte now to avoid a bubble.
                            in_ready = 1'b1;
                            if (in_valid) begin
                                shreg_nx   = in_data;
                                last_nx    = in_last;
                                bit_cnt_nx = '0;
                            end else begin
                                state_nx = STALL;
                            end
                        end
                    end
                end
            end
            STALL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx   = DATA;
                    shreg_nx   = in_data;
                    last_nx    = in_last;
                    bit_cnt_nx = '0;
                end
            end
            CRC: begin
                if (en) begin
                    out_valid  = 1'b1;
                    out_crc    = 1'b1;
                    out_bit    = lfsr[0];
                    lfsr_nx    = lfsr >> 1;
                    crc_cnt_nx = crc_cnt + CW'(1);
                    if (crc_cnt == CRC_LAST) begin
                        out_eof    = 1'b1;
                        state_nx   = IDLE;
                        crc_cnt_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // The async reset must also hold off new bytes while asserted.
        if (!rst) in_ready = 1'b0;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_crc_frame_seq.sv
// Directed and randomised frame bench for crc_frame_seq (N=8, FB=8'hcd, INIT=0).
module tb_crc_frame_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready, out_bit, out_valid, out_sof, out_crc, out_eof, busy;

    crc_frame_seq dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_sof(out_sof), .out_crc(out_crc), .out_eof(out_eof), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame description driven by run_frame
    logic [7:0] fbytes [16];
    int fnum;
    int en_mode;      // 0: always 1, 1: toggle starting 0, 2: random
    bit rand_valid;
    int stall_len;    // STALL cycles forced after the first byte (0: none)
    int abort_at;     // stop at the negedge where this output index appears (-1: none)
    bit post_valid;   // keep in_valid high after the last byte

    // Observations of the last run
    bit obits[$];
    bit ocrc[$];
    bit exp_bits[$];
    bit ref_bits[$];
    int sof_cnt, eof_cnt, sof_pos, eof_pos, stall_cnt, busy_cnt, span, ready_bad, flag_bad;
    bit timed_out;

    function automatic logic [7:0] crc_step(input logic [7:0] l, input bit b);
        return (l[0] ^ b) ? ((l >> 1) ^ 8'hcd) : (l >> 1);
    endfunction

    task automatic build_expected();
        logic [7:0] l;
        bit d;
        l = 8'h00;
        exp_bits.delete();
        for (int k = 0; k < fnum; k++) begin
            for (int b = 0; b < 8; b++) begin
                d = fbytes[k][b];
                exp_bits.push_back(d);
                l = crc_step(l, d);
            end
        end
        for (int b = 0; b < 8; b++) exp_bits.push_back(l[b]);
    endtask

    function automatic logic [7:0] remainder();
        logic [7:0] l;
        l = 8'h00;
        foreach (obits[i]) l = crc_step(l, obits[i]);
        return l;
    endfunction

    function automatic int stream_diff();
        int d;
        d = 0;
        if (obits.size() != exp_bits.size()) return -1;
        foreach (obits[i]) if (obits[i] != exp_bits[i]) d++;
        return d;
    endfunction

    function automatic logic [15:0] pack16(input bit crcq);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16 && i < obits.size(); i++) v[i] = crcq ? ocrc[i] : obits[i];
        return v;
    endfunction

    // Starts just after a rising edge; drives one cycle per iteration, samples at negedge.
    task automatic run_frame(input int max_cyc);
        int idx, gap_left, data_seen, ds0;
        bit done, started, hold;
        idx = 0; data_seen = 0; done = 0; started = 0;
        gap_left = stall_len - 1;
        obits.delete(); ocrc.delete();
        sof_cnt = 0; eof_cnt = 0; sof_pos = -1; eof_pos = -1; stall_cnt = 0;
        busy_cnt = 0; span = 0; ready_bad = 0; flag_bad = 0;
        build_expected();
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            ds0  = data_seen;
            hold = (stall_len > 0) && (idx == 1) && (data_seen < 8 || gap_left > 0);
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (cyc % 2 == 1);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            if (idx < fnum) begin
                in_data  = fbytes[idx];
                in_last  = (idx == fnum - 1);
                in_valid = !hold && (!rand_valid || $urandom_range(0, 2) != 0);
            end else begin
                in_data  = 8'ha5;
                in_last  = 1'b0;
                in_valid = post_valid;
            end
            @(negedge clk);
            if (idx >= fnum && in_ready) ready_bad++;
            if (in_valid && in_ready) begin
                idx++;
                started = 1;
            end
            if (started) span++;
            if (busy) busy_cnt++;
            if (busy && en && !out_valid) stall_cnt++;
            if (!out_valid && (out_sof || out_crc || out_eof)) flag_bad++;
            if (out_valid) begin
                if (out_sof) begin
                    sof_cnt++;
                    sof_pos = obits.size();
                end
                obits.push_back(out_bit);
                ocrc.push_back(out_crc);
                if (!out_crc) data_seen++;
                if (out_eof) begin
                    eof_cnt++;
                    eof_pos = obits.size();
                    done = 1;
                end
            end
            if (hold && ds0 >= 8) gap_left--;
            if (abort_at >= 0 && obits.size() > abort_at) begin
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        timed_out = !done;
        en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic defaults();
        en_mode = 0; rand_valid = 0; stall_len = 0; abort_at = -1; post_valid = 0;
    endtask

    task automatic test_reset();
        en = 1'b1; in_valid = 1'b1; in_data = 8'hff; in_last = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_sof, out_crc, out_eof, out_bit, busy, in_ready} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {out_valid, out_sof, out_crc, out_eof, out_bit, busy, in_ready});
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: in_ready,busy got %b want 10", {in_ready, busy});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_no_start: busy,out_valid got %b want 00", {busy, out_valid});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input logic [7:0] b, input logic [15:0] exp16, input string nm);
        defaults();
        fnum = 1; fbytes[0] = b;
        run_frame(200);
        n_cmp++;
        if (timed_out || obits.size() != 16) begin
            n_bad++;
            $display("FAIL %s_len: got %0d bits (timeout=%0d) want 16", nm, obits.size(), timed_out);
        end
        n_cmp++;
        if (pack16(0) !== exp16) begin
            n_bad++;
            $display("FAIL %s_stream: got %h want %h", nm, pack16(0), exp16);
        end
        n_cmp++;
        if (pack16(1) !== 16'hff00) begin
            n_bad++;
            $display("FAIL %s_crcflag: got %h want ff00", nm, pack16(1));
        end
        n_cmp++;
        if (sof_cnt != 1 || sof_pos != 0 || eof_cnt != 1 || eof_pos != 16) begin
            n_bad++;
            $display("FAIL %s_sof_eof: sof %0d@%0d eof %0d@%0d want 1@0 1@16",
                     nm, sof_cnt, sof_pos, eof_cnt, eof_pos);
        end
        n_cmp++;
        if (busy_cnt != 16 || flag_bad != 0) begin
            n_bad++;
            $display("FAIL %s_busy: busy %0d flag_bad %0d want 16 0", nm, busy_cnt, flag_bad);
        end
    endtask

    task automatic test_back_to_back();
        defaults();
        en_mode = 1; post_valid = 1;
        fnum = 3; fbytes[0] = 8'ha5; fbytes[1] = 8'h3c; fbytes[2] = 8'h0f;
        run_frame(400);
        n_cmp++;
        if (timed_out || stream_diff() != 0) begin
            n_bad++;
            $display("FAIL b2b_stream: diff %0d len %0d timeout %0d want diff 0 len 32",
                     stream_diff(), obits.size(), timed_out);
        end
        n_cmp++;
        if (remainder() !== 8'h00) begin
            n_bad++;
            $display("FAIL b2b_remainder: got %h want 00", remainder());
        end
        n_cmp++;
        if (stall_cnt != 0 || span != 64) begin
            n_bad++;
            $display("FAIL b2b_timing: stall %0d span %0d want 0 64", stall_cnt, span);
        end
        n_cmp++;
        if (ready_bad != 0 || sof_cnt != 1 || eof_cnt != 1) begin
            n_bad++;
            $display("FAIL b2b_ready_crc: ready_bad %0d sof %0d eof %0d want 0 1 1",
                     ready_bad, sof_cnt, eof_cnt);
        end
    endtask

    task automatic test_stall();
        defaults();
        fnum = 2; fbytes[0] = 8'h5a; fbytes[1] = 8'hc3;
        run_frame(200);
        ref_bits = obits;
        n_cmp++;
        if (timed_out || stall_cnt != 0 || stream_diff() != 0) begin
            n_bad++;
            $display("FAIL nogap: stall %0d diff %0d timeout %0d want 0 0 0",
                     stall_cnt, stream_diff(), timed_out);
        end
        stall_len = 5;
        run_frame(200);
        n_cmp++;
        if (timed_out || stall_cnt != 5 || busy_cnt != 29) begin
            n_bad++;
            $display("FAIL stall_len: stall %0d busy %0d timeout %0d want 5 29 0",
                     stall_cnt, busy_cnt, timed_out);
        end
        n_cmp++;
        if (obits != ref_bits || flag_bad != 0) begin
            n_bad++;
            $display("FAIL stall_stream: len %0d vs %0d flag_bad %0d want identical, 0",
                     obits.size(), ref_bits.size(), flag_bad);
        end
    endtask

    task automatic test_reset_mid_crc();
        bit last_crc;
        defaults();
        fnum = 1; fbytes[0] = 8'h01; abort_at = 11;
        run_frame(200);
        last_crc = (obits.size() > 0) ? ocrc[obits.size() - 1] : 1'b0;
        n_cmp++;
        if (obits.size() != 12 || last_crc !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_point: got %0d bits crc=%0d want 12 1", obits.size(), last_crc);
        end
        en = 1'b1; in_valid = 1'b1; in_data = 8'hff;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_sof, out_crc, out_eof, out_bit, busy, in_ready} !== 7'b0) begin
            n_bad++;
            $display("FAIL midrst_now: got %b want 0000000",
                     {out_valid, out_sof, out_crc, out_eof, out_bit, busy, in_ready});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b0) begin
            n_bad++;
            $display("FAIL midrst_hold: got %b want 000", {out_valid, busy, in_ready});
        end
        @(negedge clk);
        in_valid = 1'b0; en = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_release: got %b want 10", {in_ready, busy});
        end
        @(posedge clk);
        #1;
        abort_at = -1;
        run_frame(200);
        n_cmp++;
        if (timed_out || pack16(0) !== 16'h6201 || sof_pos != 0 || sof_cnt != 1 || eof_pos != 16) begin
            n_bad++;
            $display("FAIL midrst_next: stream %h sof %0d@%0d eof@%0d want 6201 1@0 16",
                     pack16(0), sof_cnt, sof_pos, eof_pos);
        end
    endtask

    task automatic test_random();
        defaults();
        en_mode = 2; rand_valid = 1;
        for (int f = 0; f < 6; f++) begin
            fnum = $urandom_range(1, 16);
            for (int k = 0; k < 16; k++) fbytes[k] = 8'($urandom_range(0, 255));
            run_frame(3000);
            n_cmp++;
            if (timed_out || obits.size() != 8 * fnum + 8 || stream_diff() != 0) begin
                n_bad++;
                $display("FAIL rand%0d_stream: len %0d want %0d diff %0d timeout %0d",
                         f, obits.size(), 8 * fnum + 8, stream_diff(), timed_out);
            end
            n_cmp++;
            if (remainder() !== 8'h00) begin
                n_bad++;
                $display("FAIL rand%0d_remainder: got %h want 00", f, remainder());
            end
            n_cmp++;
            if (sof_cnt != 1 || eof_cnt != 1 || flag_bad != 0 || ready_bad != 0) begin
                n_bad++;
                $display("FAIL rand%0d_flags: sof %0d eof %0d flag_bad %0d ready_bad %0d want 1 1 0 0",
                         f, sof_cnt, eof_cnt, flag_bad, ready_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h01, 16'h6201, "byte01");
        test_single(8'h00, 16'h0000, "byte00");
        test_back_to_back();
        test_stall();
        test_reset_mid_crc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
